// File: rtl/ib_ram_preload_ctrl.sv
// ib_ram_preload_ctrl
//   Streams IB-LUT entries from a valid/ready source into the GP1 and/or GP2
//   column-banked RAMs. A load walks GP1 (if selected) then GP2 (if selected),
//   writing one entry per accepted beat. The address is {row, col_sel}, so the
//   column bank advances fastest.
//
// Ports
//   sys_clk, rst          clock, asynchronous active-high reset
//   load_start            start pulse, only honoured in IDLE
//   load_gp_mask[1:0]     groups to load (bit0 GP1, bit1 GP2), sampled with load_start
//   load_abort            abandon the load in progress (ignored in IDLE/DONE)
//   lut_data/valid/ready  entry stream; ready is a pure state decode
//   gp1_wr_*, gp2_wr_*    registered RAM write ports (addr/data hold when en=0)
//   busy                  high from the cycle after start until done completes
//   load_done             single-cycle completion pulse
module ib_ram_preload_ctrl #(
  parameter int QUAN_SIZE         = 4,
  parameter int GP1_COL_SEL_WIDTH = 2,
  parameter int GP2_COL_SEL_WIDTH = 4
) (
  input  logic                                       sys_clk,
  input  logic                                       rst,
  input  logic                                       load_start,
  input  logic [1:0]                                 load_gp_mask,
  input  logic                                       load_abort,
  input  logic [QUAN_SIZE-1:0]                       lut_data,
  input  logic                                       lut_valid,
  output logic                                       lut_ready,
  output logic                                       gp1_wr_en,
  output logic [QUAN_SIZE+GP1_COL_SEL_WIDTH-1:0]     gp1_wr_addr,
  output logic [QUAN_SIZE-1:0]                       gp1_wr_data,
  output logic                                       gp2_wr_en,
  output logic [QUAN_SIZE+GP2_COL_SEL_WIDTH-1:0]     gp2_wr_addr,
  output logic [QUAN_SIZE-1:0]                       gp2_wr_data,
  output logic                                       busy,
  output logic                                       load_done
);

  localparam int GP1_RAM_ADDR_WIDTH = QUAN_SIZE + GP1_COL_SEL_WIDTH;
  localparam int GP2_RAM_ADDR_WIDTH = QUAN_SIZE + GP2_COL_SEL_WIDTH;
  localparam int GP1_VN_LOAD_CYCLE  = 2 ** GP1_RAM_ADDR_WIDTH;
  localparam int GP2_VN_LOAD_CYCLE  = 2 ** GP2_RAM_ADDR_WIDTH;

  // The shared counter is sized for the larger (GP2) address space.
  localparam logic [GP2_RAM_ADDR_WIDTH-1:0] GP1_LAST = GP2_RAM_ADDR_WIDTH'(GP1_VN_LOAD_CYCLE - 1);
  localparam logic [GP2_RAM_ADDR_WIDTH-1:0] GP2_LAST = GP2_RAM_ADDR_WIDTH'(GP2_VN_LOAD_CYCLE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_GP1 = 2'd1,
    S_LOAD_GP2 = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [GP2_RAM_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]                      mask_q, mask_d;
  logic                            w1_en_q, w1_en_d, w2_en_q, w2_en_d;
  logic [GP1_RAM_ADDR_WIDTH-1:0]   w1_addr_q, w1_addr_d;
  logic [GP2_RAM_ADDR_WIDTH-1:0]   w2_addr_q, w2_addr_d;
  logic [QUAN_SIZE-1:0]            w1_data_q, w1_data_d, w2_data_q, w2_data_d;
  logic                            hs;

  assign lut_ready = (state_q == S_LOAD_GP1) || (state_q == S_LOAD_GP2);
  assign hs        = lut_valid & lut_ready;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    w1_en_d   = 1'b0;
    w2_en_d   = 1'b0;
    w1_addr_d = w1_addr_q;
    w1_data_d = w1_data_q;
    w2_addr_d = w2_addr_q;
    w2_data_d = w2_data_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          mask_d = load_gp_mask;
          if (load_gp_mask[0])      state_d = S_LOAD_GP1;
          else if (load_gp_mask[1]) state_d = S_LOAD_GP2;
          else                      state_d = S_DONE;
        end
      end
      S_LOAD_GP1: begin
        // Abort wins over a same-cycle beat: that beat is dropped.
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          w1_en_d   = 1'b1;
          w1_addr_d = cnt_q[GP1_RAM_ADDR_WIDTH-1:0];
          w1_data_d = lut_data;
          if (cnt_q == GP1_LAST) state_d = mask_q[1] ? S_LOAD_GP2 : S_DONE;
        end
      end
      S_LOAD_GP2: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          w2_en_d   = 1'b1;
          w2_addr_d = cnt_q;
          w2_data_d = lut_data;
          if (cnt_q == GP2_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any state change restarts the beat count, so GP2 begins at address 0
    // and an abort leaves the counter clear.
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (hs)            cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      w1_en_q   <= 1'b0;
      w2_en_q   <= 1'b0;
      w1_addr_q <= '0;
      w2_addr_q <= '0;
      w1_data_q <= '0;
      w2_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      w1_en_q   <= w1_en_d;
      w2_en_q   <= w2_en_d;
      w1_addr_q <= w1_addr_d;
      w2_addr_q <= w2_addr_d;
      w1_data_q <= w1_data_d;
      w2_data_q <= w2_data_d;
    end
  end

  assign gp1_wr_en   = w1_en_q;
  assign gp1_wr_addr = w1_addr_q;
  assign gp1_wr_data = w1_data_q;
  assign gp2_wr_en   = w2_en_q;
  assign gp2_wr_addr = w2_addr_q;
  assign gp2_wr_data = w2_data_q;
  assign busy        = (state_q != S_IDLE);
  assign load_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ib_ram_preload_ctrl.sv
module tb_ib_ram_preload_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic [1:0] load_gp_mask = 2'b00;
  logic       load_abort = 1'b0;
  logic [3:0] lut_data = 4'h0;
  logic       lut_valid = 1'b0;
  logic       lut_ready;
  logic       gp1_wr_en, gp2_wr_en, busy, load_done;
  logic [5:0] gp1_wr_addr;
  logic [7:0] gp2_wr_addr;
  logic [3:0] gp1_wr_data, gp2_wr_data;

  ib_ram_preload_ctrl dut (
    .sys_clk(sys_clk), .rst(rst), .load_start(load_start), .load_gp_mask(load_gp_mask),
    .load_abort(load_abort), .lut_data(lut_data), .lut_valid(lut_valid), .lut_ready(lut_ready),
    .gp1_wr_en(gp1_wr_en), .gp1_wr_addr(gp1_wr_addr), .gp1_wr_data(gp1_wr_data),
    .gp2_wr_en(gp2_wr_en), .gp2_wr_addr(gp2_wr_addr), .gp2_wr_data(gp2_wr_data),
    .busy(busy), .load_done(load_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a load is a list of beats; the first 64 go to GP1 when
  // selected, the rest to GP2; completion is announced one cycle later.
  bit       m_active, m_dn;
  bit [1:0] m_mask;
  int       m_beat;
  bit       m_w1en, m_w2en;
  int       m_w1a, m_w1d, m_w2a, m_w2d;

  int n1, n2, nd, done_cyc, cyc;

  function automatic int total_beats(bit [1:0] m);
    return (m[0] ? 64 : 0) + (m[1] ? 256 : 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_dn = 0; m_mask = 0; m_beat = 0;
    m_w1en = 0; m_w2en = 0; m_w1a = 0; m_w1d = 0; m_w2a = 0; m_w2d = 0;
  endtask

  task automatic model_update();
    int n_gp1;
    m_w1en = 0; m_w2en = 0;
    if (m_dn) begin
      m_dn = 0;
    end else if (!m_active) begin
      if (load_start) begin
        m_mask = load_gp_mask;
        m_beat = 0;
        if (total_beats(m_mask) == 0) m_dn = 1;
        else m_active = 1;
      end
    end else if (load_abort) begin
      m_active = 0;
    end else if (lut_valid) begin
      n_gp1 = m_mask[0] ? 64 : 0;
      if (m_beat < n_gp1) begin m_w1en = 1; m_w1a = m_beat; m_w1d = int'(lut_data); end
      else begin m_w2en = 1; m_w2a = m_beat - n_gp1; m_w2d = int'(lut_data); end
      m_beat++;
      if (m_beat == total_beats(m_mask)) begin m_active = 0; m_dn = 1; end
    end
  endtask

  task automatic compare();
    chk("lut_ready",   int'(lut_ready),   int'(m_active));
    chk("busy",        int'(busy),        int'(m_active || m_dn));
    chk("load_done",   int'(load_done),   int'(m_dn));
    chk("gp1_wr_en",   int'(gp1_wr_en),   int'(m_w1en));
    chk("gp2_wr_en",   int'(gp2_wr_en),   int'(m_w2en));
    chk("gp1_wr_addr", int'(gp1_wr_addr), m_w1a);
    chk("gp1_wr_data", int'(gp1_wr_data), m_w1d);
    chk("gp2_wr_addr", int'(gp2_wr_addr), m_w2a);
    chk("gp2_wr_data", int'(gp2_wr_data), m_w2d);
    if (gp1_wr_en) n1++;
    if (gp2_wr_en) n2++;
    if (load_done) begin nd++; done_cyc = cyc; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, int'(lut_ready), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(load_done), 0);
    chk({tag, "_w1en"},  int'(gp1_wr_en), 0);
    chk({tag, "_w2en"},  int'(gp2_wr_en), 0);
    chk({tag, "_w1a"},   int'(gp1_wr_addr), 0);
    chk({tag, "_w1d"},   int'(gp1_wr_data), 0);
    chk({tag, "_w2a"},   int'(gp2_wr_addr), 0);
    chk({tag, "_w2d"},   int'(gp2_wr_data), 0);
  endtask

  // Inputs are set #1 after a rising edge; outputs compared on the falling edge.
  task automatic step(input bit do_rst);
    @(negedge sys_clk);
    compare();
    if (do_rst) begin
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge sys_clk);
      #1;
      rst = 1'b0;
    end else begin
      @(posedge sys_clk);
      model_update();
      #1;
    end
  endtask

  typedef struct {
    bit [1:0] mask;
    int       pct;      // lut_valid probability, percent
    int       abort_at; // beat index to abort at, -1 none
    int       rst_at;   // beat index to reset at, -1 none
    bit       noise;    // stray load_start pulses while busy
    bit       rdata;    // random data instead of beat index
    int       exp_w1, exp_w2, exp_done, exp_cyc;
  } scen_t;

  scen_t sc[9];

  task automatic run_scen(input int id, input scen_t s);
    bool_t_dummy: begin end
    n1 = 0; n2 = 0; nd = 0; done_cyc = -1; cyc = 0;
    while ((cyc == 0 || m_active || m_dn) && cyc < 2000) begin
      load_start   = (cyc == 0) || (s.noise && (m_active || m_dn) && $urandom_range(0, 7) == 0);
      load_gp_mask = (cyc == 0) ? s.mask : 2'($urandom);
      lut_valid    = $urandom_range(0, 99) < s.pct;
      lut_data     = s.rdata ? 4'($urandom) : 4'(m_beat);
      load_abort   = (s.abort_at >= 0 && m_active && m_beat == s.abort_at);
      step(s.rst_at >= 0 && m_active && m_beat == s.rst_at);
      cyc++;
    end
    chk($sformatf("s%0d_terminated", id), int'(cyc < 2000), 1);
    // Trailing idle cycles: aborts and beats must be ignored, nothing written.
    for (int i = 0; i < 3; i++) begin
      load_start = 1'b0;
      lut_valid  = 1'($urandom);
      load_abort = 1'($urandom);
      step(1'b0);
      cyc++;
    end
    chk($sformatf("s%0d_gp1_writes", id), n1, s.exp_w1);
    chk($sformatf("s%0d_gp2_writes", id), n2, s.exp_w2);
    chk($sformatf("s%0d_done_pulses", id), nd, s.exp_done);
    if (s.exp_cyc >= 0) chk($sformatf("s%0d_done_cycle", id), done_cyc, s.exp_cyc);
  endtask

  initial begin
    //            mask   pct abort rst noise rdata  w1   w2  done  cyc
    sc[0] = '{2'b11, 100, -1, -1, 1'b0, 1'b0, 64, 256, 1, 321};
    sc[1] = '{2'b10, 100, -1, -1, 1'b1, 1'b0,  0, 256, 1, 257};
    sc[2] = '{2'b00, 100, -1, -1, 1'b0, 1'b0,  0,   0, 1,   1};
    sc[3] = '{2'b01,  50, -1, -1, 1'b1, 1'b0, 64,   0, 1,  -1};
    sc[4] = '{2'b10, 100, 10, -1, 1'b0, 1'b0,  0,  10, 0,  -1};
    sc[5] = '{2'b10, 100, -1, -1, 1'b0, 1'b0,  0, 256, 1, 257};
    sc[6] = '{2'b01, 100, -1, 30, 1'b1, 1'b0, 30,   0, 0,  -1};
    sc[7] = '{2'b11,  60, -1, -1, 1'b1, 1'b1, 64, 256, 1,  -1};
    sc[8] = '{2'b01, 100, -1, -1, 1'b0, 1'b1, 64,   0, 1,  65};

    model_reset();
    cyc = 0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_zero("reset");
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    step(1'b0);

    for (int i = 0; i < 9; i++) run_scen(i, sc[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
